// File: rtl/ssd1306_pkg.sv
// Shared constants, FSM states and the address-window command table for the SSD1306 streamer.
package ssd1306_pkg;

  localparam logic [7:0] CTRL_CMD  = 8'h00;
  localparam logic [7:0] CTRL_DATA = 8'h40;
  localparam logic [7:0] SET_COL   = 8'h21;
  localparam logic [7:0] SET_PAGE  = 8'h22;

  localparam int INIT_LEN = 26;
  localparam int WIN_LEN  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT,
    ST_WIN,
    ST_DATA,
    ST_FIN
  } state_e;

  // Window transaction: 00 21 00 COLS-1 22 00 PAGES-1
  function automatic logic [7:0] win_byte(input logic [2:0] idx, input int cols, input int pages);
    case (idx)
      3'd1:    return SET_COL;
      3'd3:    return 8'(cols - 1);
      3'd4:    return SET_PAGE;
      3'd6:    return 8'(pages - 1);
      default: return CTRL_CMD;
    endcase
  endfunction

endpackage

// File: rtl/ssd1306_init_rom.sv
// Combinational init-sequence ROM; the multiplex-ratio argument tracks the PAGES parameter.
module ssd1306_init_rom
  import ssd1306_pkg::*;
#(
  parameter int PAGES = 8
) (
  input  logic [4:0] idx_i,
  output logic [7:0] byte_o
);

  always_comb begin
    byte_o = 8'h00;
    case (idx_i)
      5'd0:  byte_o = 8'hAE;
      5'd1:  byte_o = 8'hD5;
      5'd2:  byte_o = 8'h80;
      5'd3:  byte_o = 8'hA8;
      5'd4:  byte_o = 8'(PAGES * 8 - 1);
      5'd5:  byte_o = 8'hD3;
      5'd6:  byte_o = 8'h00;
      5'd7:  byte_o = 8'h40;
      5'd8:  byte_o = 8'h8D;
      5'd9:  byte_o = 8'h14;
      5'd10: byte_o = 8'h20;
      5'd11: byte_o = 8'h00;
      5'd12: byte_o = 8'hA1;
      5'd13: byte_o = 8'hC8;
      5'd14: byte_o = 8'hDA;
      5'd15: byte_o = 8'h12;
      5'd16: byte_o = 8'h81;
      5'd17: byte_o = 8'hCF;
      5'd18: byte_o = 8'hD9;
      5'd19: byte_o = 8'hF1;
      5'd20: byte_o = 8'hDB;
      5'd21: byte_o = 8'h40;
      5'd22: byte_o = 8'hA4;
      5'd23: byte_o = 8'hA6;
      5'd24: byte_o = 8'h2E;
      5'd25: byte_o = 8'hAF;
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/ssd1306_frame_streamer.sv
// SSD1306 refresh engine: init once, set window, then stream the frame buffer as chunked I2C writes
// through a byte handshake, with a frame-RAM prefetch and NACK abort.
module ssd1306_frame_streamer
  import ssd1306_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR   = 7'h3C,
  parameter int         COLS       = 128,
  parameter int         PAGES      = 8,
  parameter int         CHUNK      = 16,
  parameter int         GAP_CYCLES = 1000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic                            reinit_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            error_o,
  output logic                            fb_rd_en_o,
  output logic [$clog2(PAGES*COLS)-1:0]   fb_addr_o,
  input  logic [7:0]                      fb_data_i,
  output logic                            tx_valid_o,
  input  logic                            tx_ready_i,
  output logic [7:0]                      tx_data_o,
  output logic                            tx_first_o,
  output logic                            tx_last_o,
  output logic [6:0]                      tx_addr_o,
  input  logic                            tx_done_i,
  input  logic                            tx_nack_i
);

  localparam int FRAME   = PAGES * COLS;
  localparam int AW      = $clog2(FRAME);
  localparam int CW      = $clog2(FRAME + 1);
  localparam int GW      = $clog2(GAP_CYCLES + 1);
  localparam int TXN_MAX = (CHUNK + 1 > INIT_LEN + 1) ? CHUNK + 1 : INIT_LEN + 1;
  localparam int IW      = $clog2(TXN_MAX + 1);

  state_e          state_q, state_d, ret_q, ret_d;
  logic [IW-1:0]   idx_q, idx_d, len;
  logic [GW-1:0]   gap_q, gap_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      fbuf_q, fbuf_d, data_q, data_d, nbyte, rom_byte;
  logic [4:0]      rom_idx;
  logic            fbuf_vld_q, fbuf_vld_d, rd_pend_q, rd_en;
  logic            valid_q, valid_d, first_q, first_d, last_q, last_d;
  logic            init_done_q, init_done_d, error_q, error_d;
  logic            accept, slot_free, avail;

  // Byte 0 of the init transaction is the control byte, so the ROM is offset by one.
  assign rom_idx = 5'(idx_q - IW'(1));

  ssd1306_init_rom #(.PAGES(PAGES)) u_rom (
    .idx_i  (rom_idx),
    .byte_o (rom_byte)
  );

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    fbuf_d      = fbuf_q;
    fbuf_vld_d  = fbuf_vld_q;
    valid_d     = valid_q;
    data_d      = data_q;
    first_d     = first_q;
    last_d      = last_q;
    init_done_d = init_done_q;
    error_d     = error_q;
    rd_en       = 1'b0;
    len         = IW'(WIN_LEN);
    nbyte       = CTRL_CMD;
    avail       = 1'b1;
    accept      = valid_q && tx_ready_i;
    slot_free   = !valid_q || accept;

    if (accept) valid_d = 1'b0;

    // Next byte of the current transaction; a frame byte is only usable the cycle it returns or once buffered.
    case (state_q)
      ST_INIT: begin
        len   = IW'(INIT_LEN + 1);
        nbyte = (idx_q == '0) ? CTRL_CMD : rom_byte;
      end
      ST_WIN: nbyte = win_byte(3'(idx_q), COLS, PAGES);
      ST_DATA: begin
        len = IW'(CHUNK + 1);
        if (idx_q == '0)     nbyte = CTRL_DATA;
        else if (rd_pend_q)  nbyte = fb_data_i;
        else if (fbuf_vld_q) nbyte = fbuf_q;
        else                 avail = 1'b0;
      end
      default: ;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          error_d    = 1'b0;
          idx_d      = '0;
          cnt_d      = '0;
          addr_d     = '0;
          fbuf_vld_d = 1'b0;
          state_d    = (!init_done_q || reinit_i) ? ST_INIT : ST_WIN;
        end
      end
      ST_WAIT: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = ret_q;
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: begin
        if (rd_pend_q) begin
          fbuf_d     = fb_data_i;
          fbuf_vld_d = 1'b1;
        end
        if (slot_free && (idx_q < len) && avail) begin
          valid_d = 1'b1;
          data_d  = nbyte;
          first_d = (idx_q == '0);
          last_d  = (idx_q == len - IW'(1));
          idx_d   = idx_q + IW'(1);
          if (state_q == ST_DATA) begin
            if (idx_q != '0) begin
              fbuf_vld_d = 1'b0;
              cnt_d      = cnt_q + CW'(1);
            end
            if (idx_q < IW'(CHUNK)) begin
              rd_en  = 1'b1;
              addr_d = (addr_q == AW'(FRAME - 1)) ? '0 : addr_q + AW'(1);
            end
          end
        end
        if (tx_done_i && (idx_q == len) && !valid_q) begin
          state_d = ST_WAIT;
          idx_d   = '0;
          gap_d   = '0;
          case (state_q)
            ST_INIT: begin
              init_done_d = 1'b1;
              ret_d       = ST_WIN;
            end
            ST_WIN:  ret_d = ST_DATA;
            default: ret_d = (cnt_q == CW'(FRAME)) ? ST_FIN : ST_DATA;
          endcase
        end
      end
    endcase

    // NACK overrides everything, including a coincident tx_done.
    if (tx_nack_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      first_d = 1'b0;
      last_d  = 1'b0;
      rd_en   = 1'b0;
      error_d = 1'b1;
      if (state_q == ST_INIT) init_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_WIN;
      idx_q       <= '0;
      gap_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      fbuf_q      <= '0;
      fbuf_vld_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      init_done_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      fbuf_q      <= fbuf_d;
      fbuf_vld_q  <= fbuf_vld_d;
      rd_pend_q   <= rd_en;
      valid_q     <= valid_d;
      data_q      <= data_d;
      first_q     <= first_d;
      last_q      <= last_d;
      init_done_q <= init_done_d;
      error_q     <= error_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign done_o     = (state_q == ST_FIN);
  assign error_o    = error_q;
  assign fb_rd_en_o = rd_en;
  assign fb_addr_o  = addr_q;
  assign tx_valid_o = valid_q;
  assign tx_data_o  = data_q;
  assign tx_first_o = first_q;
  assign tx_last_o  = last_q;
  assign tx_addr_o  = I2C_ADDR;

endmodule

// File: tb/tb_ssd1306_frame_streamer.sv
// Bench for ssd1306_frame_streamer: two configurations behind one muxed master/RAM model,
// byte streams checked against an expected transaction list built from the command rules.
module tb_ssd1306_frame_streamer;

  localparam int GAP_A = 20;
  localparam int GAP_B = 37;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, reinit = 1'b0, sel = 1'b0;
  logic tx_ready = 1'b0, tx_done = 1'b0, tx_nack = 1'b0;

  logic       busy_a, done_a, err_a, rd_a, val_a, fst_a, lst_a;
  logic [7:0] data_a, fbd_a;
  logic [9:0] addr_a;
  logic [6:0] ta_a;
  logic       busy_b, done_b, err_b, rd_b, val_b, fst_b, lst_b;
  logic [7:0] data_b, fbd_b;
  logic [7:0] addr_b;
  logic [6:0] ta_b;

  logic       busy, done, error, tx_valid, tx_first, tx_last;
  logic [7:0] tx_data;

  logic [7:0] mem [1024];
  logic [7:0] init_tab [26] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                                8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                                8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'h2E, 8'hAF};

  logic [7:0] rec_d[$], exp_d[$];
  bit         rec_f[$], rec_l[$], exp_f[$], exp_l[$];
  int         gaps[$];
  int         stab_err, timeout_flag, done_seen;
  int         n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  ssd1306_frame_streamer #(.COLS(128), .PAGES(8), .CHUNK(16), .GAP_CYCLES(GAP_A)) u_dut_a (
    .clk(clk), .rst(rst), .start_i(start && !sel), .reinit_i(reinit),
    .busy_o(busy_a), .done_o(done_a), .error_o(err_a), .fb_rd_en_o(rd_a), .fb_addr_o(addr_a),
    .fb_data_i(fbd_a), .tx_valid_o(val_a), .tx_ready_i(tx_ready), .tx_data_o(data_a),
    .tx_first_o(fst_a), .tx_last_o(lst_a), .tx_addr_o(ta_a), .tx_done_i(tx_done), .tx_nack_i(tx_nack)
  );

  ssd1306_frame_streamer #(.COLS(64), .PAGES(4), .CHUNK(256), .GAP_CYCLES(GAP_B)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start && sel), .reinit_i(reinit),
    .busy_o(busy_b), .done_o(done_b), .error_o(err_b), .fb_rd_en_o(rd_b), .fb_addr_o(addr_b),
    .fb_data_i(fbd_b), .tx_valid_o(val_b), .tx_ready_i(tx_ready), .tx_data_o(data_b),
    .tx_first_o(fst_b), .tx_last_o(lst_b), .tx_addr_o(ta_b), .tx_done_i(tx_done), .tx_nack_i(tx_nack)
  );

  assign busy     = sel ? busy_b : busy_a;
  assign done     = sel ? done_b : done_a;
  assign error    = sel ? err_b  : err_a;
  assign tx_valid = sel ? val_b  : val_a;
  assign tx_first = sel ? fst_b  : fst_a;
  assign tx_last  = sel ? lst_b  : lst_a;
  assign tx_data  = sel ? data_b : data_a;

  // Synchronous RAM; garbage on non-read cycles so stale data use shows up in the stream.
  always @(posedge clk) begin
    fbd_a <= rd_a ? mem[addr_a] : 8'($urandom);
    fbd_b <= rd_b ? mem[addr_b] : 8'($urandom);
  end

  task automatic rand_mem();
    foreach (mem[i]) mem[i] = 8'($urandom);
  endtask

  function automatic void push_txn(input logic [7:0] b[$]);
    foreach (b[i]) begin
      exp_d.push_back(b[i]);
      exp_f.push_back(i == 0);
      exp_l.push_back(i == b.size() - 1);
    end
  endfunction

  function automatic void build_exp(input bit with_init, input int cols, input int pages, input int chunk);
    logic [7:0] t[$];
    exp_d.delete(); exp_f.delete(); exp_l.delete();
    if (with_init) begin
      t.push_back(8'h00);
      for (int i = 0; i < 26; i++) t.push_back((i == 4) ? 8'(pages * 8 - 1) : init_tab[i]);
      push_txn(t);
    end
    t.delete();
    t.push_back(8'h00); t.push_back(8'h21); t.push_back(8'h00); t.push_back(8'(cols - 1));
    t.push_back(8'h22); t.push_back(8'h00); t.push_back(8'(pages - 1));
    push_txn(t);
    for (int k = 0; k < cols * pages / chunk; k++) begin
      t.delete();
      t.push_back(8'h40);
      for (int j = 0; j < chunk; j++) t.push_back(mem[k * chunk + j]);
      push_txn(t);
    end
  endfunction

  function automatic int first_diff();
    int n = (rec_d.size() < exp_d.size()) ? rec_d.size() : exp_d.size();
    for (int i = 0; i < n; i++)
      if (rec_d[i] !== exp_d[i] || rec_f[i] !== exp_f[i] || rec_l[i] !== exp_l[i]) return i;
    return (rec_d.size() == exp_d.size()) ? -1 : n;
  endfunction

  task automatic pulse_start(input bit ri);
    @(negedge clk); start = 1'b1; reinit = ri;
    @(negedge clk); start = 1'b0; reinit = 1'b0;
  endtask

  // I2C master model: random ready, tx_done a few cycles after the last byte, optional NACK/reset abort.
  task automatic run(input int stall_pct, input int abort_at, input bit abort_rst, input int max_cyc);
    int cyc = 0, dly = -1, done_cyc = -1;
    logic [7:0] pd = '0;
    logic pf = 1'b0, pl = 1'b0, pstall = 1'b0, pvalid = 1'b0;
    rec_d.delete(); rec_f.delete(); rec_l.delete(); gaps.delete();
    stab_err = 0; timeout_flag = 0; done_seen = 0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0; tx_nack = 1'b0;
      if (!busy) begin done_seen = int'(done); break; end
      if (cyc++ >= max_cyc) begin timeout_flag = 1; break; end
      if (pstall && (!tx_valid || tx_data !== pd || tx_first !== pf || tx_last !== pl)) stab_err++;
      if (tx_valid && !pvalid && done_cyc >= 0) begin gaps.push_back(cyc - done_cyc); done_cyc = -1; end
      pvalid = tx_valid;
      if (dly == 0) begin tx_done = 1'b1; done_cyc = cyc; end
      if (dly >= 0) dly--;
      if (abort_at >= 0 && rec_d.size() == abort_at) begin
        tx_ready = 1'b0;
        if (abort_rst) rst = 1'b1; else tx_nack = 1'b1;
        abort_at = -1; pstall = 1'b0;
        continue;
      end
      tx_ready = ($urandom_range(99) >= stall_pct);
      if (tx_valid && tx_ready) begin
        rec_d.push_back(tx_data); rec_f.push_back(tx_first); rec_l.push_back(tx_last);
        if (tx_last) dly = 2;
      end
      pstall = tx_valid && !tx_ready;
      pd = tx_data; pf = tx_first; pl = tx_last;
    end
  endtask

  task automatic test_reset();
    string      nm[9] = '{"busy", "done", "error", "fb_rd_en", "tx_valid", "tx_first", "tx_last", "tx_data", "fb_addr"};
    logic [15:0] ob[9];
    rst = 1'b1;
    repeat (3) @(negedge clk);
    ob = '{16'(busy_a), 16'(done_a), 16'(err_a), 16'(rd_a), 16'(val_a), 16'(fst_a), 16'(lst_a), 16'(data_a), 16'(addr_a)};
    foreach (ob[i]) begin
      n_cmp++;
      if (ob[i] !== 16'h0) begin $display("FAIL reset_%s: got %0h want 0", nm[i], ob[i]); n_bad++; end
    end
    rst = 1'b0;
  endtask

  task automatic test_first_frame();
    int d, badgap = 0;
    rand_mem(); build_exp(1, 128, 8, 16);
    pulse_start(1'b0);
    run(0, -1, 1'b0, 20000);
    n_cmp++; if (timeout_flag != 0) begin $display("FAIL first_timeout: frame did not finish"); n_bad++; end
    d = first_diff();
    n_cmp++; if (d != -1) begin $display("FAIL first_stream: diff at byte %0d, got %0d bytes want %0d", d, rec_d.size(), exp_d.size()); n_bad++; end
    n_cmp++; if (done_seen != 1) begin $display("FAIL first_done: got %0d want 1", done_seen); n_bad++; end
    n_cmp++; if (ta_a !== 7'h3C) begin $display("FAIL first_addr: got %h want 3c", ta_a); n_bad++; end
    // 1 cycle to register tx_done, GAP wait cycles, 1 cycle to load the next byte.
    foreach (gaps[i]) if (gaps[i] != GAP_A + 2) badgap++;
    n_cmp++; if (gaps.size() != 65 || badgap != 0) begin
      $display("FAIL first_gap: got %0d gaps (%0d wrong) want 65 of %0d", gaps.size(), badgap, GAP_A + 2); n_bad++;
    end
  endtask

  task automatic test_frame(input string nm, input bit ri, input bit with_init, input int stall);
    int d;
    rand_mem(); build_exp(with_init, 128, 8, 16);
    pulse_start(ri);
    run(stall, -1, 1'b0, 20000);
    d = first_diff();
    n_cmp++; if (d != -1 || timeout_flag != 0) begin
      $display("FAIL %s_stream: diff at byte %0d, got %0d bytes want %0d, timeout %0d", nm, d, rec_d.size(), exp_d.size(), timeout_flag); n_bad++;
    end
    n_cmp++; if (done_seen != 1) begin $display("FAIL %s_done: got %0d want 1", nm, done_seen); n_bad++; end
    n_cmp++; if (stab_err != 0) begin $display("FAIL %s_stall_stable: got %0d violations want 0", nm, stab_err); n_bad++; end
  endtask

  task automatic test_nack_data();
    pulse_start(1'b0);
    run(0, 7 + 5 * 17 + 2, 1'b0, 20000);
    n_cmp++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL nack_outputs: got valid %b busy %b want 0 0", tx_valid, busy); n_bad++;
    end
    n_cmp++; if (error !== 1'b1) begin $display("FAIL nack_error: got %b want 1", error); n_bad++; end
    n_cmp++; if (done_seen != 0) begin $display("FAIL nack_done: got %0d want 0", done_seen); n_bad++; end
    pulse_start(1'b0);
    n_cmp++; if (error !== 1'b0) begin $display("FAIL nack_clear: got %b want 0", error); n_bad++; end
    run(0, -1, 1'b0, 20000);
  endtask

  task automatic test_nack_init();
    pulse_start(1'b1);
    run(0, 5, 1'b0, 20000);
    n_cmp++; if (error !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL nack_init: got error %b busy %b want 1 0", error, busy); n_bad++;
    end
  endtask

  task automatic test_reset_mid();
    string      nm[9] = '{"busy", "done", "error", "fb_rd_en", "tx_valid", "tx_first", "tx_last", "tx_data", "fb_addr"};
    logic [15:0] ob[9];
    pulse_start(1'b0);
    run(0, 7 + 3 * 17 + 4, 1'b1, 20000);
    ob = '{16'(busy_a), 16'(done_a), 16'(err_a), 16'(rd_a), 16'(val_a), 16'(fst_a), 16'(lst_a), 16'(data_a), 16'(addr_a)};
    foreach (ob[i]) begin
      n_cmp++;
      if (ob[i] !== 16'h0) begin $display("FAIL rstmid_%s: got %0h want 0", nm[i], ob[i]); n_bad++; end
    end
    rst = 1'b0;
  endtask

  task automatic test_small_cfg();
    int d, badgap = 0;
    sel = 1'b1;
    rand_mem(); build_exp(1, 64, 4, 256);
    pulse_start(1'b0);
    run(20, -1, 1'b0, 20000);
    d = first_diff();
    n_cmp++; if (d != -1 || timeout_flag != 0) begin
      $display("FAIL small_stream: diff at byte %0d, got %0d bytes want %0d, timeout %0d", d, rec_d.size(), exp_d.size(), timeout_flag); n_bad++;
    end
    n_cmp++; if (done_seen != 1) begin $display("FAIL small_done: got %0d want 1", done_seen); n_bad++; end
    foreach (gaps[i]) if (gaps[i] != GAP_B + 2) badgap++;
    n_cmp++; if (gaps.size() != 2 || badgap != 0) begin
      $display("FAIL small_gap: got %0d gaps (%0d wrong) want 2 of %0d", gaps.size(), badgap, GAP_B + 2); n_bad++;
    end
    n_cmp++; if (ta_b !== 7'h3C) begin $display("FAIL small_addr: got %h want 3c", ta_b); n_bad++; end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_frame("noinit", 1'b0, 1'b0, 0);
    test_frame("stall", 1'b0, 1'b0, 40);
    test_frame("reinit", 1'b1, 1'b1, 10);
    test_nack_data();
    test_frame("after_nack", 1'b0, 1'b0, 0);
    test_nack_init();
    test_frame("after_init_nack", 1'b0, 1'b1, 0);
    test_reset_mid();
    test_frame("after_rst", 1'b0, 1'b1, 15);
    test_small_cfg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
